p405s_icu_fill_drain: RTL and testbench
=======================================

# p405s_icu_fill_drain

Line-fill drain engine for the ICU. It is the reader side of the ICU datapath capture registers. It accepts PLB read-data beats for one cache line, in any order, into an 8-entry word buffer. It then writes them to the I-cache array write port in critical-word-first wrap order under a req/ack handshake. It also forwards the critical word to the fetch path as soon as it lands.

## Interface
Parameters:
- DW, 32, data word width
- WORDS, 8, words per cache line (power of two)
- WA, 3, word index width, log2(WORDS)

Ports:
- CB  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- fillStart  in  1  begin a new line fill; sampled only in IDLE
- fillCritWd  in  [0:WA-1]  critical word index, captured with fillStart
- plbDataVal  in  1  PLB read beat valid
- plbWdAddr  in  [0:WA-1]  word index of the beat
- plbData  in  [0:DW-1]  beat data
- arrWrReq  out  1  array write request
- arrWrAck  in  1  array accepts the current word
- arrWrWd  out  [0:WA-1]  word index being written
- arrWrData  out  [0:DW-1]  word data being written
- bypVal  out  1  one-cycle pulse: critical word valid on bypData
- bypData  out  [0:DW-1]  critical word
- fillBusy  out  1  high from fillStart acceptance until done
- fillDone  out  1  one-cycle pulse after last array write acked
- fillDupErr  out  1  one-cycle pulse: beat for an already-valid word

## Operation
- States: IDLE, FILL, DONE.
- IDLE -> FILL on fillStart.
  - Capture fillCritWd into drainPtr.
  - Clear all valid bits and the drained count.
- In FILL, each plbDataVal beat writes the buffer at plbWdAddr and sets that word's valid bit.
- A beat to an already-valid word:
  - data is dropped (first write wins);
  - fillDupErr pulses.
- Drain runs in parallel with fill.
  - arrWrReq asserts when valid[drainPtr] is set in the registered state.
  - arrWrWd = drainPtr, arrWrData = buf[drainPtr].
- Handshake:
  - arrWrReq, arrWrWd and arrWrData stay stable until arrWrAck.
  - On a cycle with req && ack, drainPtr increments modulo WORDS (wraps 7 -> 0) and the drained count increments.
  - Ack without req is ignored.
- After the WORDS-th ack:
  - FILL -> DONE;
  - arrWrReq deasserts the same edge.
- DONE: fillDone pulses for one cycle, then the state returns to IDLE and fillBusy drops.
- Bypass: on the cycle a beat for the captured critical index is written, bypVal asserts the next cycle with bypData = that word. Fires at most once per fill.
- Beats in IDLE or DONE are ignored.
- fillStart outside IDLE is ignored.
- Reset, including mid-fill, has priority over all events:
  - state = IDLE, all valid bits = 0, drainPtr = 0, count = 0;
  - all outputs 0 (buffer data is not cleared).

## Timing
- Beat at cycle N to the word at drainPtr gives arrWrReq at N+1 at the earliest. The buffer is read only from registered state, with no same-cycle flow-through.
- Simultaneous beat to word k and ack of word k-1: k is written at edge N, and req for k is presented at N+1.
- Sustained throughput is one word per cycle when ack is held high and beats are in order.
- Best-case fill is fillStart at 0 and beats at 1..8 in critical order with ack always high. Writes ack at cycles 2..9, fillDone is at cycle 10, and fillBusy is low at cycle 11.
- bypVal is one cycle after the critical beat.

## Configuration
- P405S_ICU_FILL_BYPASS_EN defined: the bypass path is present as described.
- Not defined:
  - bypVal is tied to 0 and bypData is tied to 0;
  - the critical word is delivered only via the array write;
  - all other behaviour is identical.

## Structure
- Shared package p405s_icu_pkg holds:
  - ICU_LINE_WORDS (8) and ICU_WD_IDX_W (3);
  - the fill state enum (IDLE/FILL/DONE).
- Sub-module p405s_icu_fill_buf holds:
  - WORDS x DW storage plus valid vector;
  - write port (idx, data, we), clear, registered read at drainPtr, valid lookup.
- The top level holds the FSM, drainPtr and counter, bypass, and the error pulse.

## Test plan
- In-order fill: fillCritWd=0, beats 0..7 with data 0x1000_0000+i, ack high. Expect 8 writes, wd 0..7 with matching data, bypData=0x1000_0000, and fillDone at cycle 10.
- Critical wrap: fillCritWd=5, beats in order 5,6,7,0..4. Expect write order 5,6,7,0,1,2,3,4 and bypVal one cycle after the beat for word 5.
- Out-of-order with backpressure:
  - fillCritWd=2, beats arrive 7,3,2,0,1,6,4,5;
  - ack is low for 3 cycles on the first request;
  - req/data stay stable while ack is low;
  - writes follow order 2,3,4,5,6,7,0,1, each only after its word is valid.
- Duplicate beat: word 4 sent twice (0xAAAA_AAAA then 0x5555_5555). Expect fillDupErr to pulse once and array word 4 = 0xAAAA_AAAA.
- Reset mid-fill: Reset after 3 acks. Next cycle all outputs are 0 and state is IDLE. A new fill with fillCritWd=1 completes correctly with no stale valid bits.
- Bypass compiled out: rerun the critical-wrap scenario without P405S_ICU_FILL_BYPASS_EN. Expect bypVal to stay 0 and array writes to be identical.

Source files
------------

// File: rtl/p405s_icu_pkg.sv
// Shared ICU definitions: line geometry and the line-fill state encoding.
package p405s_icu_pkg;

    localparam int unsigned ICU_LINE_WORDS = 8;
    localparam int unsigned ICU_WD_IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/p405s_icu_fill_drain_if.sv
// Fill-drain bundle: fill control, PLB read beats, array write port, bypass and status.
// master drives fill/PLB/ack; slave is the drain engine.
interface p405s_icu_fill_drain_if
    import p405s_icu_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned WA = ICU_WD_IDX_W
);
    logic          fillStart;
    logic [0:WA-1] fillCritWd;
    logic          plbDataVal;
    logic [0:WA-1] plbWdAddr;
    logic [0:DW-1] plbData;
    logic          arrWrReq;
    logic          arrWrAck;
    logic [0:WA-1] arrWrWd;
    logic [0:DW-1] arrWrData;
    logic          bypVal;
    logic [0:DW-1] bypData;
    logic          fillBusy;
    logic          fillDone;
    logic          fillDupErr;

    modport master (
        output fillStart, fillCritWd, plbDataVal, plbWdAddr, plbData, arrWrAck,
        input  arrWrReq, arrWrWd, arrWrData, bypVal, bypData, fillBusy, fillDone, fillDupErr
    );

    modport slave (
        input  fillStart, fillCritWd, plbDataVal, plbWdAddr, plbData, arrWrAck,
        output arrWrReq, arrWrWd, arrWrData, bypVal, bypData, fillBusy, fillDone, fillDupErr
    );

endinterface

// File: rtl/p405s_icu_fill_buf.sv
// Line word buffer: WORDS x DW storage with per-word valid bits.
// Reads are muxed straight out of the storage registers, so a word written at
// an edge is visible only from the following cycle.
module p405s_icu_fill_buf
    import p405s_icu_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned WORDS = ICU_LINE_WORDS,
    parameter int unsigned WA    = ICU_WD_IDX_W
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          we_i,
    input  logic [0:WA-1] wr_idx_i,
    input  logic [0:DW-1] wr_data_i,
    input  logic [0:WA-1] rd_idx_i,
    output logic [0:DW-1] rd_data_o,
    output logic          rd_valid_o,
    input  logic [0:WA-1] lk_idx_i,
    output logic          lk_valid_o
);

    logic [0:DW-1]    mem_q [WORDS];
    logic [WORDS-1:0] valid_q;

    // Word storage; contents survive reset, the valid bits gate their use
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Valid vector: cleared by reset or at the start of a fill, set per written word
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (clr_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    assign rd_data_o  = mem_q[rd_idx_i];
    assign rd_valid_o = valid_q[rd_idx_i];
    assign lk_valid_o = valid_q[lk_idx_i];

endmodule

// File: rtl/p405s_icu_fill_drain.sv
// ICU line-fill drain engine: gathers PLB beats for one line in any order and
// writes them to the I-cache array in critical-word-first wrap order.
// Optional critical-word bypass to fetch: define P405S_ICU_FILL_BYPASS_EN.
module p405s_icu_fill_drain
    import p405s_icu_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned WORDS = ICU_LINE_WORDS,
    parameter int unsigned WA    = ICU_WD_IDX_W
) (
    input logic                   CB,
    input logic                   Reset,
    p405s_icu_fill_drain_if.slave fill
);

    fill_state_e   state_q, state_d;
    logic [0:WA-1] ptr_q, ptr_d;
    logic [WA:0]   cnt_q, cnt_d;
    logic          dup_q;

    logic          fill_go;
    logic          buf_clr;
    logic          beat_we;
    logic          beat_dup;
    logic          req;
    logic [0:DW-1] rd_data;
    logic          rd_valid;
    logic          lk_valid;

    p405s_icu_fill_buf #(
        .DW    (DW),
        .WORDS (WORDS),
        .WA    (WA)
    ) u_buf (
        .clk_i      (CB),
        .rst_i      (Reset),
        .clr_i      (buf_clr),
        .we_i       (beat_we),
        .wr_idx_i   (fill.plbWdAddr),
        .wr_data_i  (fill.plbData),
        .rd_idx_i   (ptr_q),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid),
        .lk_idx_i   (fill.plbWdAddr),
        .lk_valid_o (lk_valid)
    );

    // FSM next state, drain pointer/count update and beat acceptance
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        fill_go  = 1'b0;
        buf_clr  = 1'b0;
        beat_we  = 1'b0;
        beat_dup = 1'b0;
        req      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fill.fillStart) begin
                    fill_go = 1'b1;
                    buf_clr = 1'b1;
                    ptr_d   = fill.fillCritWd;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                req = rd_valid;
                if (fill.plbDataVal) begin
                    // First write wins; a repeat beat is flagged and dropped
                    beat_dup = lk_valid;
                    beat_we  = !lk_valid;
                end
                if (req && fill.arrWrAck) begin
                    ptr_d = ptr_q + WA'(1);
                    cnt_d = cnt_q + (WA + 1)'(1);
                    if (cnt_q == (WA + 1)'(WORDS - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, pointer, count and error-pulse registers
    always_ff @(posedge CB) begin
        if (Reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            dup_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            dup_q   <= beat_dup;
        end
    end

    // Idle write port drives zeros so nothing stale shows outside a request
    assign fill.arrWrReq   = req;
    assign fill.arrWrWd    = req ? ptr_q : '0;
    assign fill.arrWrData  = req ? rd_data : '0;
    assign fill.fillBusy   = (state_q != IDLE);
    assign fill.fillDone   = (state_q == DONE);
    assign fill.fillDupErr = dup_q;

`ifdef P405S_ICU_FILL_BYPASS_EN
    logic [0:WA-1] crit_q;
    logic          byp_val_q;
    logic [0:DW-1] byp_data_q;
    logic          byp_hit;

    // Duplicates never reach beat_we, so this fires once per fill
    assign byp_hit = beat_we && (fill.plbWdAddr == crit_q);

    // Critical index capture and one-cycle bypass of the critical word
    always_ff @(posedge CB) begin
        if (Reset) begin
            crit_q     <= '0;
            byp_val_q  <= 1'b0;
            byp_data_q <= '0;
        end else begin
            if (fill_go) begin
                crit_q <= fill.fillCritWd;
            end
            byp_val_q <= byp_hit;
            if (byp_hit) begin
                byp_data_q <= fill.plbData;
            end
        end
    end

    assign fill.bypVal  = byp_val_q;
    assign fill.bypData = byp_data_q;
`else
    logic unused_fill_go;
    assign unused_fill_go = fill_go;
    assign fill.bypVal    = 1'b0;
    assign fill.bypData   = '0;
`endif

endmodule

// File: tb/tb_p405s_icu_fill_drain.sv
// Self-checking bench for p405s_icu_fill_drain. Array writes are checked by a
// scoreboard loaded in wrap order at each fill start; scenario tasks check
// timing, bypass, error pulse and reset behaviour inline.
module tb_p405s_icu_fill_drain;

    typedef struct {
        logic [0:2]  wd;
        logic [0:31] data;
    } wr_t;

    logic CB    = 1'b0;
    logic Reset = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    wr_t         exp_q[$];
    logic [0:31] md[8];
    logic        mvalid[8];
    int          ack_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [0:2]  prev_wd;
    logic [0:31] prev_data;

    p405s_icu_fill_drain_if #(.DW(32), .WA(3)) fi ();

    p405s_icu_fill_drain #(
        .DW    (32),
        .WORDS (8),
        .WA    (3)
    ) u_dut (
        .CB    (CB),
        .Reset (Reset),
        .fill  (fi.slave)
    );

    always #5 CB = ~CB;
    always @(posedge CB) cyc <= cyc + 1;

    // Scoreboard monitor: ordering, data, stability under stall, no early request
    always @(negedge CB) begin
        if (Reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_checks++;
                if (fi.arrWrReq !== 1'b1 || fi.arrWrWd !== prev_wd || fi.arrWrData !== prev_data) begin
                    n_fail++;
                    $display("FAIL stall_hold: got req=%b wd=%0d data=%h required req=1 wd=%0d data=%h",
                             fi.arrWrReq, fi.arrWrWd, fi.arrWrData, prev_wd, prev_data);
                end
            end
            if (fi.arrWrReq === 1'b1) begin
                n_checks++;
                if (!mvalid[fi.arrWrWd]) begin
                    n_fail++;
                    $display("FAIL req_before_valid: got req for wd=%0d required word valid first",
                             fi.arrWrWd);
                end
            end
            if (fi.arrWrReq === 1'b1 && fi.arrWrAck === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got wd=%0d data=%h required no write",
                             fi.arrWrWd, fi.arrWrData);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (fi.arrWrWd !== e.wd || fi.arrWrData !== e.data) begin
                        n_fail++;
                        $display("FAIL array_write: got wd=%0d data=%h required wd=%0d data=%h",
                                 fi.arrWrWd, fi.arrWrData, e.wd, e.data);
                    end
                end
                ack_cnt++;
            end
            prev_stall = (fi.arrWrReq === 1'b1) && (fi.arrWrAck !== 1'b1);
            prev_wd    = fi.arrWrWd;
            prev_data  = fi.arrWrData;
        end
    end

    task automatic tick();
        @(posedge CB);
        #1;
    endtask

    // Load the scoreboard in wrap order and issue fillStart; c0 is the start cycle
    task automatic start_fill(input int crit, output int c0);
        for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
        ack_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            wr_t e;
            e.wd   = 3'((crit + k) % 8);
            e.data = md[(crit + k) % 8];
            exp_q.push_back(e);
        end
        fi.fillStart  = 1'b1;
        fi.fillCritWd = crit[2:0];
        c0 = cyc;
        tick();
        fi.fillStart = 1'b0;
    endtask

    task automatic beat(input int w, input logic [0:31] d);
        fi.plbDataVal = 1'b1;
        fi.plbWdAddr  = w[2:0];
        fi.plbData    = d;
        tick();
        fi.plbDataVal = 1'b0;
        mvalid[w] = 1'b1;
    endtask

    // Returns the cycle fillDone was seen, or -1 on timeout
    task automatic wait_done(output int dc);
        dc = -1;
        for (int c = 0; c < 40; c++) begin
            if (fi.fillDone === 1'b1) begin
                dc = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if (fi.arrWrReq !== 1'b0 || fi.fillBusy !== 1'b0 || fi.fillDone !== 1'b0 ||
            fi.fillDupErr !== 1'b0 || fi.bypVal !== 1'b0 || fi.arrWrData !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%b busy=%b done=%b dup=%b byp=%b data=%h required all 0",
                     fi.arrWrReq, fi.fillBusy, fi.fillDone, fi.fillDupErr, fi.bypVal, fi.arrWrData);
        end
        Reset = 1'b0;
        tick();
        n_checks++;
        if (fi.fillBusy !== 1'b0 || fi.arrWrReq !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b req=%b required 0 0", fi.fillBusy, fi.arrWrReq);
        end
    endtask

    task automatic test_in_order();
        int c0, dc;
        logic        exp_bv;
        logic [0:31] exp_bd;
        for (int i = 0; i < 8; i++) md[i] = 32'h1000_0000 + i;
`ifdef P405S_ICU_FILL_BYPASS_EN
        exp_bv = 1'b1; exp_bd = md[0];
`else
        exp_bv = 1'b0; exp_bd = 32'h0;
`endif
        fi.arrWrAck = 1'b1;
        start_fill(0, c0);
        n_checks++;
        if (fi.fillBusy !== 1'b1 || fi.arrWrReq !== 1'b0) begin
            n_fail++;
            $display("FAIL inorder_start: got busy=%b req=%b required 1 0", fi.fillBusy, fi.arrWrReq);
        end
        for (int i = 0; i < 8; i++) begin
            beat(i, md[i]);
            if (i == 0) begin
                n_checks++;
                if (fi.bypVal !== exp_bv || fi.bypData !== exp_bd) begin
                    n_fail++;
                    $display("FAIL inorder_bypass: got val=%b data=%h required val=%b data=%h",
                             fi.bypVal, fi.bypData, exp_bv, exp_bd);
                end
            end
        end
        wait_done(dc);
        n_checks++;
        if (dc != c0 + 10) begin
            n_fail++;
            $display("FAIL inorder_done_cycle: got %0d required %0d", dc - c0, 10);
        end
        tick();
        n_checks++;
        if (fi.fillBusy !== 1'b0 || fi.fillDone !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL inorder_end: got busy=%b done=%b pending=%0d required 0 0 0",
                     fi.fillBusy, fi.fillDone, exp_q.size());
        end
    endtask

    task automatic test_crit_wrap();
        int c0, dc;
        logic        exp_bv;
        logic [0:31] exp_bd;
        for (int i = 0; i < 8; i++) md[i] = 32'hC0DE_0000 + (i * 32'h111);
`ifdef P405S_ICU_FILL_BYPASS_EN
        exp_bv = 1'b1; exp_bd = md[5];
`else
        exp_bv = 1'b0; exp_bd = 32'h0;
`endif
        fi.arrWrAck = 1'b1;
        start_fill(5, c0);
        for (int k = 0; k < 8; k++) begin
            beat((5 + k) % 8, md[(5 + k) % 8]);
            n_checks++;
            if (k == 0) begin
                if (fi.bypVal !== exp_bv || fi.bypData !== exp_bd) begin
                    n_fail++;
                    $display("FAIL wrap_bypass: got val=%b data=%h required val=%b data=%h",
                             fi.bypVal, fi.bypData, exp_bv, exp_bd);
                end
            end else if (fi.bypVal !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_bypass_once: got val=%b at beat %0d required 0", fi.bypVal, k);
            end
        end
        wait_done(dc);
        n_checks++;
        if (dc != c0 + 10 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_done: got cycle %0d pending %0d required cycle 10 pending 0",
                     dc - c0, exp_q.size());
        end
        tick();
    endtask

    task automatic test_backpressure();
        int c0, dc, bi, held;
        int ord[8] = '{7, 3, 2, 0, 1, 6, 4, 5};
        for (int i = 0; i < 8; i++) md[i] = 32'hB000_0000 + (i << 4);
        bi = 0;
        held = 0;
        fi.arrWrAck = 1'b0;
        start_fill(2, c0);
        for (int c = 0; c < 60 && fi.fillDone !== 1'b1; c++) begin
            if (bi < 8) begin
                fi.plbDataVal = 1'b1;
                fi.plbWdAddr  = 3'(ord[bi]);
                fi.plbData    = md[ord[bi]];
            end else begin
                fi.plbDataVal = 1'b0;
            end
            fi.arrWrAck = (held >= 3);
            if (fi.arrWrReq === 1'b1 && !fi.arrWrAck) held++;
            tick();
            if (bi < 8) begin
                mvalid[ord[bi]] = 1'b1;
                bi++;
            end
        end
        fi.plbDataVal = 1'b0;
        fi.arrWrAck   = 1'b1;
        wait_done(dc);
        n_checks++;
        if (dc < 0 || held != 3 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL backpressure_done: got done=%0d stalls=%0d pending=%0d required done stalls=3 pending=0",
                     dc, held, exp_q.size());
        end
        tick();
    endtask

    task automatic test_dup();
        int c0, dc, dups;
        int          seq[9]  = '{0, 1, 2, 3, 4, 4, 5, 6, 7};
        logic [0:31] dat[9];
        for (int i = 0; i < 8; i++) md[i] = 32'h2000_0000 + i;
        md[4] = 32'hAAAA_AAAA;
        for (int s = 0; s < 9; s++) dat[s] = md[seq[s]];
        dat[5] = 32'h5555_5555;
        dups = 0;
        fi.arrWrAck = 1'b1;
        start_fill(0, c0);
        for (int s = 0; s < 9; s++) begin
            beat(seq[s], dat[s]);
            if (fi.fillDupErr === 1'b1) dups++;
            n_checks++;
            if (fi.fillDupErr !== (s == 5)) begin
                n_fail++;
                $display("FAIL dup_pulse: got %b after beat %0d required %b", fi.fillDupErr, s, (s == 5));
            end
        end
        wait_done(dc);
        n_checks++;
        if (dc < 0 || dups != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL dup_done: got done=%0d pulses=%0d pending=%0d required done pulses=1 pending=0",
                     dc, dups, exp_q.size());
        end
        tick();
    endtask

    task automatic test_reset_mid_fill();
        int c0, dc;
        for (int i = 0; i < 8; i++) md[i] = 32'h3000_0000 + i;
        fi.arrWrAck = 1'b1;
        start_fill(0, c0);
        for (int i = 0; i < 8; i++) begin
            beat(i, md[i]);
            if (ack_cnt >= 3) break;
        end
        n_checks++;
        if (ack_cnt != 3) begin
            n_fail++;
            $display("FAIL mid_acks: got %0d required 3", ack_cnt);
        end
        Reset = 1'b1;
        tick();
        exp_q.delete();
        n_checks++;
        if (fi.arrWrReq !== 1'b0 || fi.arrWrWd !== 3'd0 || fi.arrWrData !== 32'h0 ||
            fi.bypVal !== 1'b0 || fi.bypData !== 32'h0 || fi.fillBusy !== 1'b0 ||
            fi.fillDone !== 1'b0 || fi.fillDupErr !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got req=%b wd=%0d data=%h byp=%b bd=%h busy=%b done=%b dup=%b required all 0",
                     fi.arrWrReq, fi.arrWrWd, fi.arrWrData, fi.bypVal, fi.bypData,
                     fi.fillBusy, fi.fillDone, fi.fillDupErr);
        end
        Reset = 1'b0;
        for (int i = 0; i < 8; i++) md[i] = 32'h4000_0000 + i;
        start_fill(1, c0);
        n_checks++;
        if (fi.arrWrReq !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_valid: got req=%b wd=%0d required 0", fi.arrWrReq, fi.arrWrWd);
        end
        for (int k = 0; k < 8; k++) beat((1 + k) % 8, md[(1 + k) % 8]);
        wait_done(dc);
        n_checks++;
        if (dc != c0 + 10 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL refill_done: got cycle %0d pending %0d required cycle 10 pending 0",
                     dc - c0, exp_q.size());
        end
        tick();
    endtask

    initial begin
        fi.fillStart  = 1'b0;
        fi.fillCritWd = '0;
        fi.plbDataVal = 1'b0;
        fi.plbWdAddr  = '0;
        fi.plbData    = '0;
        fi.arrWrAck   = 1'b0;
        for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
        test_reset();
        test_in_order();
        test_crit_wrap();
        test_backpressure();
        test_dup();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
